// File: rtl/extender_if.sv
// Decode-stage immediate bus: request (valid/opcode/immediate) and registered result.
// The extender takes the slave side; the producer drives the master side.
interface extender_if #(
    parameter int IMM_W  = 14,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6
);
    logic              in_valid;
    logic [OP_W-1:0]   opcode;
    logic [IMM_W-1:0]  imm_in;
    logic [DATA_W-1:0] imm_out;
    logic              out_valid;
    logic              zext_out;

    modport master (
        output in_valid, opcode, imm_in,
        input  imm_out, out_valid, zext_out
    );

    modport slave (
        input  in_valid, opcode, imm_in,
        output imm_out, out_valid, zext_out
    );
endinterface

// File: rtl/extender.sv
// Immediate extender: zero-extends for ZEXT_OP (ORI), sign-extends otherwise; 1-cycle registered.
// Optional EXTENDER_STATS_EN adds zero-/sign-extension event counters.
module extender #(
    parameter int              IMM_W   = 14,
    parameter int              DATA_W  = 32,
    parameter int              OP_W    = 6,
    parameter logic [OP_W-1:0] ZEXT_OP = OP_W'(6'b000100)
) (
    input  logic        clk,
    input  logic        rst_n,
    extender_if.slave   bus
`ifdef EXTENDER_STATS_EN
    ,
    output logic [15:0] zext_cnt,
    output logic [15:0] sext_cnt
`endif
);

    if (DATA_W < IMM_W) begin : g_width_err
        $error("extender: DATA_W must be >= IMM_W");
    end

    function automatic logic [DATA_W-1:0] zero_ext(input logic [IMM_W-1:0] v);
        return DATA_W'(v);
    endfunction

    // Sized cast of a signed operand replicates the MSB; DATA_W == IMM_W degenerates to a copy.
    function automatic logic [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] v);
        logic signed [IMM_W-1:0] vs;
        vs = v;
        return DATA_W'(vs);
    endfunction

    logic [DATA_W-1:0] imm_d, imm_q;
    logic              zext_d, zext_q;
    logic              vld_q;

    always_comb begin
        zext_d = (bus.opcode == ZEXT_OP);
        imm_d  = zext_d ? zero_ext(bus.imm_in) : sign_ext(bus.imm_in);
    end

    // Data only loads on accepted inputs, so X on an idle bus never reaches imm_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q  <= '0;
            zext_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                imm_q  <= imm_d;
                zext_q <= zext_d;
            end
        end
    end

    assign bus.imm_out   = imm_q;
    assign bus.zext_out  = zext_q;
    assign bus.out_valid = vld_q;

`ifdef EXTENDER_STATS_EN
    logic [15:0] zcnt_q, scnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zcnt_q <= '0;
            scnt_q <= '0;
        end else if (bus.in_valid) begin
            if (zext_d) zcnt_q <= zcnt_q + 16'd1;
            else        scnt_q <= scnt_q + 16'd1;
        end
    end

    assign zext_cnt = zcnt_q;
    assign sext_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_extender.sv
// Bench for extender: directed vector table, valid/hold and async-reset sequences,
// then randomized traffic against an arithmetic reference model.
module tb_extender;
    localparam logic [5:0] ORI  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] BZ   = 6'b000110;
    localparam logic [5:0] J    = 6'b000010;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    extender_if #(.IMM_W(14), .DATA_W(32), .OP_W(6)) bus ();

`ifdef EXTENDER_STATS_EN
    logic [15:0] zext_cnt, sext_cnt;
`endif

    extender dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef EXTENDER_STATS_EN
        ,
        .zext_cnt (zext_cnt),
        .sext_cnt (sext_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_imm;
    logic        exp_vld;
    logic        exp_z;
    int          exp_zc;
    int          exp_sc;

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [13:0] imm;
        logic [31:0] e_imm;
        logic        e_z;
    } vec_t;

    vec_t vecs[$];

    // Reference: the immediate read as a 14-bit two's-complement number unless the opcode is ORI.
    function automatic logic [31:0] model_ext(input logic [5:0] op, input logic [13:0] imm);
        int val;
        val = int'(imm);
        if (op != ORI && val >= 8192) val = val - 16384;
        return 32'(val);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".imm_out"},   bus.imm_out,         exp_imm);
        check({tag, ".out_valid"}, 32'(bus.out_valid),  32'(exp_vld));
        check({tag, ".zext_out"},  32'(bus.zext_out),   32'(exp_z));
`ifdef EXTENDER_STATS_EN
        check({tag, ".zext_cnt"},  32'(zext_cnt),       32'(exp_zc[15:0]));
        check({tag, ".sext_cnt"},  32'(sext_cnt),       32'(exp_sc[15:0]));
`endif
    endtask

    task automatic model_reset();
        exp_imm = '0;
        exp_vld = 1'b0;
        exp_z   = 1'b0;
        exp_zc  = 0;
        exp_sc  = 0;
    endtask

    // Drive one cycle, let the edge happen, update the model, sample 1 time unit later.
    task automatic apply(input logic v, input logic [5:0] op, input logic [13:0] imm);
        bus.in_valid = v;
        bus.opcode   = op;
        bus.imm_in   = imm;
        @(posedge clk);
        #1;
        exp_vld = v;
        if (v) begin
            exp_imm = model_ext(op, imm);
            exp_z   = (op == ORI);
            if (op == ORI) exp_zc++;
            else           exp_sc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.imm_in   = '0;
        rst_n        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");

        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{1'b1, 6'b000000, 14'h0000, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, ORI,  14'h1234, 32'h00001234, 1'b1});
        vecs.push_back('{1'b1, ORI,  14'h3FFF, 32'h00003FFF, 1'b1});
        vecs.push_back('{1'b1, ADDI, 14'h1234, 32'h00001234, 1'b0});
        vecs.push_back('{1'b1, ADDI, 14'h3234, 32'hFFFFF234, 1'b0});
        vecs.push_back('{1'b1, LW,   14'h1FFF, 32'h00001FFF, 1'b0});
        vecs.push_back('{1'b1, LW,   14'h2000, 32'hFFFFE000, 1'b0});
        vecs.push_back('{1'b1, BZ,   14'h0100, 32'h00000100, 1'b0});
        vecs.push_back('{1'b1, BZ,   14'h3F00, 32'hFFFFFF00, 1'b0});
        vecs.push_back('{1'b1, J,    14'h2000, 32'hFFFFE000, 1'b0});
        vecs.push_back('{1'b1, 6'b111111, 14'h3FFF, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{1'b1, ORI,  14'h2000, 32'h00002000, 1'b1});

        foreach (vecs[i]) begin
            apply(vecs[i].v, vecs[i].op, vecs[i].imm);
            check($sformatf("vec%0d.imm_out", i),   bus.imm_out,        vecs[i].e_imm);
            check($sformatf("vec%0d.zext_out", i),  32'(bus.zext_out),  32'(vecs[i].e_z));
            check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'h1);
`ifdef EXTENDER_STATS_EN
            check($sformatf("vec%0d.zext_cnt", i),  32'(zext_cnt),      32'(exp_zc[15:0]));
            check($sformatf("vec%0d.sext_cnt", i),  32'(sext_cnt),      32'(exp_sc[15:0]));
`endif
        end

        // Valid/hold: invalid cycles (including X inputs) must keep the previous result.
        apply(1'b1, ADDI, 14'h3234);
        check("hold.v1.imm",  bus.imm_out, 32'hFFFFF234);
        check("hold.v1.vld",  32'(bus.out_valid), 32'h1);
        apply(1'b0, ORI, 14'h0055);
        check("hold.v0.imm",  bus.imm_out, 32'hFFFFF234);
        check("hold.v0.vld",  32'(bus.out_valid), 32'h0);
        check("hold.v0.z",    32'(bus.zext_out), 32'h0);
        apply(1'b0, 6'bxxxxxx, 14'bxxxxxxxxxxxxxx);
        check("hold.x.imm",   bus.imm_out, 32'hFFFFF234);
        check_outputs("hold.x");
        apply(1'b1, ORI, 14'h0001);
        check("hold.v1b.imm", bus.imm_out, 32'h00000001);
        check("hold.v1b.z",   32'(bus.zext_out), 32'h1);
        check("hold.v1b.vld", 32'(bus.out_valid), 32'h1);

        // Asynchronous reset between clock edges, with a non-zero result in flight.
        apply(1'b1, ORI, 14'h3FFF);
        check_outputs("prerst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, LW, 14'h2000);
        check("postrst.imm", bus.imm_out, 32'hFFFFE000);
        check_outputs("postrst");

        // Randomized traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            logic        v;
            logic [5:0]  op;
            logic [13:0] imm;
            v   = ($urandom_range(0, 3) != 0);
            op  = ($urandom_range(0, 3) == 0) ? ORI : 6'($urandom);
            imm = 14'($urandom);
            apply(v, op, imm);
            check_outputs($sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/extender.md
Name: extender

Overview:
- Immediate extender for the pipelined RISC decode stage.
- Widens the 14-bit instruction immediate to a 32-bit operand.
- Zero-extends for ORI; sign-extends for every other opcode (ADDI, LW, BZ, J, default).
- Registered output with valid qualifier; result is consumed by the ID/EX operand path.

Parameters:
- IMM_W, 14, immediate input width
- DATA_W, 32, output width; must be >= IMM_W (elaboration error otherwise)
- OP_W, 6, opcode width
- ZEXT_OP, 6'b000100, the single opcode selecting zero extension (ORI)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  opcode/imm_in qualify this cycle
- opcode  input  OP_W  instruction opcode
- imm_in  input  IMM_W  raw immediate field
- imm_out  output  DATA_W  registered extended immediate
- out_valid  output  1  imm_out holds a result captured last cycle
- zext_out  output  1  1 = last captured result was zero-extended, 0 = sign-extended

Interface:
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n low, any time, independent of clk): imm_out=0, out_valid=0, zext_out=0; optional counters cleared. Takes effect immediately, mid-operation included; the first capture occurs on the first rising clk edge after rst_n deasserts.
- Extension function (combinational):
  - If opcode == ZEXT_OP: ext = {(DATA_W-IMM_W) zeros, imm_in}, kind = 1.
  - Otherwise: ext = {(DATA_W-IMM_W) copies of imm_in[IMM_W-1], imm_in}, kind = 0. This covers unknown/undefined opcodes.
  - DATA_W == IMM_W: ext = imm_in unchanged for both kinds.
- Latency: 1 cycle. On a rising edge with in_valid=1: imm_out<=ext, zext_out<=kind, out_valid<=1.
- On a rising edge with in_valid=0: out_valid<=0; imm_out and zext_out hold their previous values.
- No backpressure; a new input is accepted every cycle. Back-to-back valid inputs produce back-to-back results.
- Only imm_in[IMM_W-1] determines the sign. Upper bits are fully replicated; no other bits are altered.
- X on opcode or imm_in while in_valid=0 must not change imm_out.

Optional Feature:
- Macro: EXTENDER_STATS_EN
- Defined:
  - Adds outputs zext_cnt[15:0] and sext_cnt[15:0].
  - Each increments by 1 on every accepted (in_valid=1) zero-extend or sign-extend respectively.
  - Counters wrap 16'hFFFF -> 0 and reset to 0 on rst_n low.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 between edges -> imm_out=0, out_valid=0, zext_out=0 immediately. Deassert, opcode=000000, imm_in=14'h0000, in_valid=1 -> next cycle imm_out=32'h00000000, zext_out=0.
- ORI: opcode=000100 with imm_in=14'h1234 -> 32'h00001234; with imm_in=14'h3FFF -> 32'h00003FFF, zext_out=1 (no sign fill).
- ADDI/LW sign extension:
  - ADDI with 14'h1234 -> 32'h00001234; ADDI with 14'h3234 -> 32'hFFFFF234.
  - LW with 14'h1FFF -> 32'h00001FFF; LW with 14'h2000 -> 32'hFFFFE000.
- BZ/J: BZ 14'h0100 -> 32'h00000100; BZ 14'h3F00 -> 32'hFFFFFF00; J 14'h2000 -> 32'hFFFFE000.
- Hold/valid: alternate in_valid 1,0,1 with changing inputs -> out_valid 1,0,1 one cycle later; imm_out unchanged during the invalid cycle. Assert rst_n mid-stream -> outputs clear asynchronously.
- Scoreboard every cycle: expected = (opcode==000100) ? zero-ext(imm_in) : sign-ext(imm_in), delayed one cycle. With EXTENDER_STATS_EN, the counters equal the count of accepted ORI and non-ORI inputs respectively.
